// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder with NUM_REGS 32-bit read/write registers, byte strobes,
// SLVERR on out-of-range words, and a flat export of the register contents.
module axi4lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,

    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,

    output logic [NUM_REGS*32-1:0]            regs_out
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a beat transfers on a rising edge where VALID && READY.
    // VALID, once raised by the source, stays up with stable payload until
    // that edge; READY here is decoded from registered state only.

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write channel state
    logic                          aw_held;
    logic                          w_held;
    logic [IDX_W-1:0]              aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;

    // Read channel state
    logic                          rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    logic                          aw_fire;
    logic                          w_fire;
    logic                          ar_fire;
    logic                          commit;
    logic                          aw_in_range;
    logic [IDX_W-1:0]              ar_idx;
    logic                          ar_in_range;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;

    assign s_axi_awready = !aw_held && !bvalid_q;
    assign s_axi_wready  = !w_held && !bvalid_q;
    assign s_axi_arready = !rvalid_q;

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;

    assign commit      = aw_held && w_held;
    assign aw_in_range = ({1'b0, aw_idx_q} < NUM_REGS_W);

    assign ar_idx      = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_in_range = ({1'b0, ar_idx} < NUM_REGS_W);

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            // Commit takes priority; neither channel can fire while both are held.
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (commit && aw_in_range) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (aw_idx_q == IDX_W'(k)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs[k][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) begin
                rd_val = regs[k];
            end
        end
    end

    // Sampling regs here with a simultaneous commit naturally yields the pre-write value.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= ar_in_range ? rd_val : '0;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_out[32*k +: 32] = regs[k];
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: directed scenarios plus a
// randomized phase checked against an array model of the register file.
module tb_axi4lite_slave_regs;

    localparam int AW = 5;
    localparam int NR = 4;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [AW-1:0] s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [NR*32-1:0] regs_out;

    axi4lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .regs_out(regs_out)
    );

    // Clock / reset
    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model and read scoreboard
    logic [31:0] model [NR];
    logic [31:0] exp_q [$];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] r;
        for (int k = 0; k < NR; k++) r[32*k +: 32] = model[k];
        return r;
    endfunction

    function automatic void model_write(logic [AW-1:0] addr, logic [31:0] data, logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / 4;
        return (idx < NR) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(logic [AW-1:0] addr);
        return (int'(addr) / 4 < NR) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NR; k++) model[k] = '0;
    endfunction

    // Driver tasks
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay,
                             output logic [1:0] resp);
        int  budget;
        logic aw_f, w_f;
        budget = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        while ((s_axi_awvalid || s_axi_wvalid) && budget < 20) begin
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_f) s_axi_awvalid = 1'b0;
            if (w_f)  s_axi_wvalid = 1'b0;
            budget++;
        end
        while (!s_axi_bvalid && budget < 40) begin
            tick();
            budget++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_cmp++;
        if (s_axi_bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, s_axi_bvalid);
            resp = 2'bxx;
            return;
        end
        repeat (bdelay) tick();
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        int  budget;
        logic fire;
        budget = 0;
        fire = 1'b0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        while (!fire && budget < 20) begin
            fire = s_axi_arready;
            tick();
            budget++;
        end
        s_axi_arvalid = 1'b0;
        n_cmp++;
        if (!fire || s_axi_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, s_axi_rvalid);
            data = 'x; resp = 2'bxx;
            return;
        end
        repeat (rdelay) tick();
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (10) tick();
        ARESETN = 1'b1;
        model_clear();
        n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b required 0", s_axi_bvalid); end
        n_cmp++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b required 0", s_axi_rvalid); end
        n_cmp++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            n_fail++; $display("FAIL reset_readies: got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
        n_cmp++; if (regs_out !== '0) begin n_fail++; $display("FAIL reset_regs_out: got %h required 0", regs_out); end
    endtask

    task automatic test_seq_write_read();
        logic [1:0]  resp;
        logic [31:0] data;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(4*i), 32'(i + 1), 4'hF, 0, resp);
            model_write(AW'(4*i), 32'(i + 1), 4'hF);
            n_cmp++; if (resp !== 2'b00) begin n_fail++; $display("FAIL seq_bresp[%0d]: got %b required 00", i, resp); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(4*i), 0, data, resp);
            n_cmp++; if (data !== model_read(AW'(4*i)) || resp !== 2'b00) begin
                n_fail++; $display("FAIL seq_read[%0d]: got %h/%b required %h/00", i, data, resp, model_read(AW'(4*i))); end
        end
        n_cmp++; if (regs_out !== 128'h00000004_00000003_00000002_00000001) begin
            n_fail++; $display("FAIL seq_regs_out: got %h required 00000004000000030000000200000001", regs_out); end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle
    task automatic ordered_write(input logic [AW-1:0] addr, input logic [31:0] data, input int lead);
        int gap;
        gap = (lead < 0) ? -lead : lead;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = 4'hF;
        if (lead == 0) begin
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end else begin
            if (lead > 0) s_axi_wvalid = 1'b1; else s_axi_awvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            for (int i = 1; i < gap; i++) begin
                n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL order_gap_bvalid lead=%0d: got %b required 0", lead, s_axi_bvalid); end
                tick();
            end
            if (lead > 0) s_axi_awvalid = 1'b1; else s_axi_wvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        end
        n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL order_bvalid_early lead=%0d: got %b required 0", lead, s_axi_bvalid); end
        tick();
        n_cmp++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            n_fail++; $display("FAIL order_bvalid_edge lead=%0d: got %b/%b required 1/00", lead, s_axi_bvalid, s_axi_bresp); end
        model_write(addr, data, 4'hF);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic test_channel_order();
        logic [1:0]  resp;
        logic [31:0] data;
        ordered_write(5'h04, 32'hDEADBEEF, 3);
        ordered_write(5'h08, 32'h12345678, -1);
        ordered_write(5'h0C, 32'hA5A5A5A5, 0);
        n_cmp++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL order_regs_out: got %h required %h", regs_out, model_flat()); end
        for (int i = 1; i < 4; i++) begin
            axi_read(AW'(4*i), 1, data, resp);
            n_cmp++; if (data !== model_read(AW'(4*i))) begin n_fail++; $display("FAIL order_read[%0d]: got %h required %h", i, data, model_read(AW'(4*i))); end
        end
    endtask

    task automatic test_strobes_backpressure();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_write(5'h00, 32'h11223344, 4'hF, 0, resp);
        model_write(5'h00, 32'h11223344, 4'hF);
        s_axi_awaddr = 5'h00; s_axi_wdata = 32'hAABBCCDD; s_axi_wstrb = 4'h5;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        model_write(5'h00, 32'hAABBCCDD, 4'h5);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
                n_fail++; $display("FAIL bp_hold[%0d]: bvalid/awready/wready got %b required 100", i, {s_axi_bvalid, s_axi_awready, s_axi_wready}); end
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b required 0", s_axi_bvalid); end
        axi_read(5'h00, 0, data, resp);
        n_cmp++; if (data !== 32'h11BB33DD || data !== model_read(5'h00)) begin
            n_fail++; $display("FAIL strobe_read: got %h required 11bb33dd", data); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, resp);
        model_write(5'h10, 32'hFFFFFFFF, 4'hF);
        n_cmp++; if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b required 10", resp); end
        n_cmp++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL oor_regs_out: got %h required %h", regs_out, model_flat()); end
        s_axi_araddr = 5'h14; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({s_axi_rvalid, s_axi_arready} !== 2'b10 || s_axi_rdata !== 32'h0 || s_axi_rresp !== 2'b10) begin
                n_fail++; $display("FAIL oor_read_hold[%0d]: rvalid/arready=%b rdata=%h rresp=%b required 10/0/10",
                                   i, {s_axi_rvalid, s_axi_arready}, s_axi_rdata, s_axi_rresp); end
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        n_cmp++; if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
            n_fail++; $display("FAIL oor_read_release: got %b required 01", {s_axi_rvalid, s_axi_arready}); end
    endtask

    task automatic test_collision_and_reset();
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] pre;
        axi_write(5'h08, 32'h3, 4'hF, 0, resp);
        model_write(5'h08, 32'h3, 4'hF);
        s_axi_awaddr = 5'h08; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 5'h08; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        pre = model_read(5'h08);
        model_write(5'h08, 32'h55, 4'hF);
        n_cmp++; if ({s_axi_bvalid, s_axi_rvalid} !== 2'b11 || s_axi_rdata !== pre) begin
            n_fail++; $display("FAIL collision_read: bvalid/rvalid=%b rdata=%h required 11/%h", {s_axi_bvalid, s_axi_rvalid}, s_axi_rdata, pre); end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        axi_read(5'h08, 0, data, resp);
        n_cmp++; if (data !== model_read(5'h08)) begin n_fail++; $display("FAIL collision_reread: got %h required %h", data, model_read(5'h08)); end

        s_axi_awaddr = 5'h00; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        n_cmp++; if (s_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_bvalid: got %b required 1", s_axi_bvalid); end
        ARESETN = 1'b0;
        tick();
        model_clear();
        n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_bvalid: got %b required 0", s_axi_bvalid); end
        n_cmp++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL midreset_regs_out: got %h required 0", regs_out); end
        ARESETN = 1'b1;
        tick();
        n_cmp++; if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b110) begin
            n_fail++; $display("FAIL midreset_after: awready/wready/bvalid got %b required 110", {s_axi_awready, s_axi_wready, s_axi_bvalid}); end
    endtask

    task automatic test_random();
        logic [1:0]    resp;
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    st;
        logic [31:0]   exp;
        for (int i = 0; i < 60; i++) begin
            addr = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                axi_write(addr, wd, st, $urandom_range(0, 3), resp);
                model_write(addr, wd, st);
                n_cmp++; if (resp !== model_resp(addr)) begin n_fail++; $display("FAIL rand_bresp[%0d] addr=%h: got %b required %b", i, addr, resp, model_resp(addr)); end
            end else begin
                exp_q.push_back(model_read(addr));
                axi_read(addr, $urandom_range(0, 3), data, resp);
                exp = exp_q.pop_front();
                n_cmp++; if (data !== exp || resp !== model_resp(addr)) begin
                    n_fail++; $display("FAIL rand_read[%0d] addr=%h: got %h/%b required %h/%b", i, addr, data, resp, exp, model_resp(addr)); end
            end
        end
        n_cmp++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL rand_regs_out: got %h required %h", regs_out, model_flat()); end
    endtask

    initial begin
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        model_clear();

        test_reset();
        test_seq_write_read();
        test_channel_order();
        test_strobes_backpressure();
        test_out_of_range();
        test_collision_and_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
